// File: rtl/osc_multiwave.sv
// rtl/osc_multiwave.sv - multi-mode waveform oscillator with bus-mapped registers
//
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   valid/ready          bus request / one-cycle acknowledge
//   wstrb, addr, wdata   byte strobes (0 = read), byte address (addr[3:2] decoded), write data
//   rdata                read data, valid while ready=1
//   out                  registered waveform sample
//   sync                 new-period pulse aligned with out (only with OSC_MULTIWAVE_SYNC_EN)
//
// Registers (addr[3:2]): 0 DIV, 1 CTRL {enable, mode[1:0]}, 2 DUTY, 3 STATUS {dir, phase} (RO).
// Optional feature macro: OSC_MULTIWAVE_SYNC_EN adds the sync output.

module osc_multiwave #(
    parameter int OUT_W = 8,
    parameter int DIV_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             valid,
    output logic             ready,
    input  logic [3:0]       wstrb,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
`ifdef OSC_MULTIWAVE_SYNC_EN
    output logic             sync,
`endif
    output logic [OUT_W-1:0] out
);

    localparam logic [OUT_W-1:0] MAX = '1;

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] counter;
    logic [2:0]       ctrl_q;
    logic [OUT_W-1:0] duty_q;
    logic [OUT_W-1:0] phase;
    logic             dir;

    logic [1:0]       sel;
    logic             accept;
    logic             wr;
    logic             ctl_rst;
    logic             running;
    logic             tick;
    logic [31:0]      rd_value;
    logic [31:0]      merged;
    logic [OUT_W-1:0] wave;
    logic [OUT_W-1:0] phase_n;
    logic             dir_n;
    logic             new_period;
    logic             unused_addr;

    assign unused_addr = ^{addr[31:4], addr[1:0]};

    assign sel     = addr[3:2];
    assign accept  = valid & ~ready;
    assign wr      = accept & (|wstrb);
    // Any strobed write to DIV or CTRL restarts the waveform from phase 0.
    assign ctl_rst = wr & (sel == 2'd0 || sel == 2'd1);
    assign running = ctrl_q[2] & (div_q != '0);
    assign tick    = (counter == div_q);

    function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                                input logic [3:0]  strb,
                                                input logic [31:0] data);
        logic [31:0] r;
        r = cur;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                r[8*i +: 8] = data[8*i +: 8];
            end
        end
        return r;
    endfunction

    // Current (pre-write) value of the selected register; also the base for byte merging.
    always_comb begin
        rd_value = '0;
        case (sel)
            2'd0:    rd_value[DIV_W-1:0] = div_q;
            2'd1:    rd_value[2:0]       = ctrl_q;
            2'd2:    rd_value[OUT_W-1:0] = duty_q;
            default: rd_value[OUT_W:0]   = {dir, phase};
        endcase
    end

    assign merged = merge_bytes(rd_value, wstrb, wdata);

    always_comb begin
        wave = phase;
        case (ctrl_q[1:0])
            2'd1:    wave = ~phase;
            2'd3:    wave = (phase < duty_q) ? MAX : '0;
            default: wave = phase;
        endcase
    end

    // Triangle bounces at the ends without dwelling: MAX -> MAX-1 and 0 -> 1.
    always_comb begin
        phase_n    = phase + OUT_W'(1);
        dir_n      = dir;
        new_period = (phase == MAX);
        if (ctrl_q[1:0] == 2'd2) begin
            new_period = dir & (phase == '0);
            if (!dir) begin
                if (phase == MAX) begin
                    dir_n   = 1'b1;
                    phase_n = MAX - OUT_W'(1);
                end
            end else begin
                if (phase == '0) begin
                    dir_n   = 1'b0;
                    phase_n = OUT_W'(1);
                end else begin
                    phase_n = phase - OUT_W'(1);
                end
            end
        end
    end

`ifdef OSC_MULTIWAVE_SYNC_EN
    // Set on the wrapping tick, presented one clock later so it lines up with out.
    logic sync_pend;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ready   <= 1'b0;
            rdata   <= '0;
            div_q   <= '0;
            ctrl_q  <= '0;
            duty_q  <= '0;
            counter <= '0;
            phase   <= '0;
            dir     <= 1'b0;
            out     <= '0;
`ifdef OSC_MULTIWAVE_SYNC_EN
            sync      <= 1'b0;
            sync_pend <= 1'b0;
`endif
        end else begin
            ready <= accept;
            rdata <= accept ? rd_value : '0;

            if (wr) begin
                case (sel)
                    2'd0:    div_q  <= merged[DIV_W-1:0];
                    2'd1:    ctrl_q <= merged[2:0];
                    2'd2:    duty_q <= merged[OUT_W-1:0];
                    default: ;
                endcase
            end

            if (ctl_rst || !running) begin
                counter <= '0;
                phase   <= '0;
                dir     <= 1'b0;
                out     <= '0;
`ifdef OSC_MULTIWAVE_SYNC_EN
                sync      <= 1'b0;
                sync_pend <= 1'b0;
`endif
            end else begin
                counter <= tick ? '0 : counter + DIV_W'(1);
                if (tick) begin
                    phase <= phase_n;
                    dir   <= dir_n;
                end
                out <= wave;
`ifdef OSC_MULTIWAVE_SYNC_EN
                sync      <= sync_pend;
                sync_pend <= tick & new_period;
`endif
            end
        end
    end

endmodule

// File: tb/tb_osc_multiwave.sv
// tb/tb_osc_multiwave.sv - randomized self-checking bench for osc_multiwave

module tb_osc_multiwave;

    localparam int OUT_W = 8;
    localparam int DIV_W = 32;
    localparam int MAXV  = (1 << OUT_W) - 1;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             valid = 1'b0;
    logic             ready;
    logic [3:0]       wstrb = '0;
    logic [31:0]      addr = '0;
    logic [31:0]      wdata = '0;
    logic [31:0]      rdata;
    logic [OUT_W-1:0] out;
`ifdef OSC_MULTIWAVE_SYNC_EN
    logic             sync;
`endif

    int errors = 0;
    int checks = 0;
    bit mon_on = 1'b0;

    always #5 clk = ~clk;

    osc_multiwave #(.OUT_W(OUT_W), .DIV_W(DIV_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .valid  (valid),
        .ready  (ready),
        .wstrb  (wstrb),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
`ifdef OSC_MULTIWAVE_SYNC_EN
        .sync   (sync),
`endif
        .out    (out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the waveform is a pure function of the number of ticks
    // elapsed since the last restart, and ticks occur every DIV+1 running clocks.
    typedef struct packed {
        bit             ready;
        bit [31:0]      rdata;
        bit [31:0]      div;
        bit [2:0]       ctrl;
        bit [OUT_W-1:0] duty;
        bit [31:0]      cnt;
        bit [31:0]      t;
        bit [OUT_W-1:0] out;
        bit             sync;
        bit             pend;
    } model_t;

    model_t m = '0;

    function automatic int phase_of(input longint t, input int mode);
        longint p;
        if (mode == 2) begin
            p = t % (2 * MAXV);
            return int'((p <= MAXV) ? p : (2 * MAXV - p));
        end
        return int'(t % (MAXV + 1));
    endfunction

    function automatic int dir_of(input longint t, input int mode);
        longint p;
        if (mode != 2) return 0;
        p = t % (2 * MAXV);
        return ((p > MAXV) || (p == 0 && t > 0)) ? 1 : 0;
    endfunction

    function automatic bit new_period(input longint t, input int mode);
        if (mode == 2) return (t % (2 * MAXV) == 0) && (t > 0);
        return phase_of(t, mode) == MAXV;
    endfunction

    function automatic bit [31:0] merge(input bit [31:0] cur, input bit [3:0] strb, input bit [31:0] d);
        bit [31:0] r;
        r = cur;
        for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic model_t model_next(input model_t s, input bit rn, input bit v,
                                          input bit [3:0] strb, input bit [31:0] a, input bit [31:0] d);
        model_t nx;
        bit acc, wr, crst, run, tick;
        int mode, sel, ph;
        bit [31:0] cur, mg;
        nx = s;
        if (!rn) return '0;
        acc  = v && !s.ready;
        sel  = int'(a[3:2]);
        wr   = acc && (strb != 0);
        mode = int'(s.ctrl[1:0]);
        case (sel)
            0:       cur = s.div;
            1:       cur = 32'(s.ctrl);
            2:       cur = 32'(s.duty);
            default: cur = 32'(dir_of(s.t, mode) * (MAXV + 1) + phase_of(s.t, mode));
        endcase
        run  = s.ctrl[2] && (s.div != 0);
        crst = wr && (sel < 2);
        if (crst || !run) begin
            nx.cnt = 0; nx.t = 0; nx.out = 0; nx.sync = 0; nx.pend = 0;
        end else begin
            ph = phase_of(s.t, mode);
            case (mode)
                1:       nx.out = OUT_W'(MAXV - ph);
                3:       nx.out = (ph < int'(s.duty)) ? OUT_W'(MAXV) : '0;
                default: nx.out = OUT_W'(ph);
            endcase
            nx.sync = s.pend;
            tick    = (longint'(s.cnt) % (longint'(s.div) + 1)) == longint'(s.div);
            nx.cnt  = s.cnt + 1;
            nx.pend = 0;
            if (tick) begin
                nx.pend = new_period(s.t, mode);
                nx.t    = s.t + 1;
            end
        end
        if (wr) begin
            mg = merge(cur, strb, d);
            case (sel)
                0:       nx.div  = mg;
                1:       nx.ctrl = mg[2:0];
                2:       nx.duty = mg[OUT_W-1:0];
                default: ;
            endcase
        end
        nx.ready = acc;
        nx.rdata = acc ? cur : 0;
        return nx;
    endfunction

    always @(posedge clk) m <= model_next(m, resetn, valid, wstrb, addr, wdata);

    always @(negedge clk) begin
        if (mon_on) begin
            check("ready", 32'(ready), 32'(m.ready));
            if (m.ready) check("rdata", rdata, m.rdata);
            check("out", 32'(out), 32'(m.out));
`ifdef OSC_MULTIWAVE_SYNC_EN
            check("sync", 32'(sync), 32'(m.sync));
`endif
        end
    end

    task automatic bus(input bit [1:0] sel, input bit [3:0] strb, input bit [31:0] data);
        @(negedge clk);
        valid = 1'b1;
        addr  = ($urandom & 32'hFFFF_FFF3) | {28'b0, sel, 2'b00};
        wstrb = strb;
        wdata = data;
        @(negedge clk);
        valid = 1'b0;
        wstrb = '0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bit [1:0] s;
        repeat (3) @(posedge clk);
        @(negedge clk);
        mon_on = 1'b1;
        resetn = 1'b1;

        for (int i = 0; i < 4; i++) bus(2'(i), 4'h0, $urandom);

        // Saw-up, one tick every 4 clocks, through a wrap.
        bus(2'd0, 4'hF, 32'd3);
        bus(2'd1, 4'h1, 32'h4);
        idle(1100);
        bus(2'd3, 4'h0, 0);

        // Triangle across two full periods, reading STATUS during descent.
        bus(2'd0, 4'hF, 32'd1);
        bus(2'd1, 4'h1, 32'h6);
        idle(700);
        bus(2'd3, 4'h0, 0);
        idle(1400);

        // Square with a mid-run duty change.
        bus(2'd2, 4'h1, 32'd64);
        bus(2'd1, 4'h1, 32'h7);
        idle(600);
        bus(2'd2, 4'h1, 32'd128);
        idle(600);

        // Stop conditions.
        bus(2'd1, 4'h1, 32'h3);
        idle(20);
        bus(2'd1, 4'h1, 32'h7);
        bus(2'd0, 4'hF, 32'd0);
        idle(20);

        for (int seg = 0; seg < 12; seg++) begin
            bus(2'd0, 4'hF, $urandom_range(0, 3));
            bus(2'd2, 4'h1, $urandom_range(0, 255));
            bus(2'd1, 4'h1, ($urandom_range(0, 5) == 0) ? $urandom_range(0, 7) : (32'h4 | $urandom_range(0, 3)));
            for (int c = 0; c < 1500; c++) begin
                @(negedge clk);
                if ($urandom_range(0, 15) == 0) begin
                    s     = 2'($urandom_range(0, 3));
                    valid = 1'b1;
                    addr  = ($urandom & 32'hFFFF_FFF3) | {28'b0, s, 2'b00};
                    if (s < 2) begin
                        wstrb = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
                        wdata = (s == 0) ? $urandom_range(0, 3) : $urandom;
                    end else begin
                        wstrb = 4'($urandom);
                        wdata = $urandom;
                    end
                end else begin
                    valid = 1'b0;
                    wstrb = '0;
                end
            end
            valid = 1'b0;
            wstrb = '0;
        end

        // Reset in the middle of a transaction while running.
        bus(2'd0, 4'hF, 32'd0 + 1);
        bus(2'd1, 4'h1, 32'h4);
        idle(50);
        @(negedge clk);
        valid = 1'b1;
        addr  = 32'h0000_0004;
        wstrb = 4'h0;
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) bus(2'(i), 4'h0, 0);
        idle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
